// File: rtl/img_chk_pkg.sv
// Shared definitions for the image stream checker: state encoding,
// width helpers and pixel channel slicing.
package img_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // Extra bit on per-channel differences so 0x00 vs 0xFF cannot wrap.
    localparam int DIFF_EXTRA = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int idx_w(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int chan_lsb(input int ch, input int dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/img_stream_checker_fifo.sv
// Show-ahead synchronous FIFO with flush. A write to a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module stream_fifo
    import img_chk_pkg::*;
#(
    parameter int DW_TOTAL = 24,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [DW_TOTAL-1:0] wr_data,
    input  logic                rd_en,
    output logic [DW_TOTAL-1:0] rd_data,
    output logic                full,
    output logic                empty
);

    localparam int AW = clog2(DEPTH);

    logic [DW_TOTAL-1:0] mem_q [DEPTH];
    logic [DW_TOTAL-1:0] mem_d [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                push;
    logic                pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/img_stream_checker.sv
// Frame comparator: buffers DUT and golden pixel streams, pops matched pairs,
// and reports mismatch count, first-error coordinates and pass/fail.
module img_stream_checker
    import img_chk_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int CHANNELS   = 3,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TOL        = 0,
    parameter int ERR_W      = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       start,
    input  logic                       dut_valid,
    input  logic [CHANNELS*DW-1:0]     dut_data,
    input  logic                       ref_valid,
    input  logic [CHANNELS*DW-1:0]     ref_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [idx_w(WIDTH)-1:0]    first_err_x,
    output logic [idx_w(HEIGHT)-1:0]   first_err_y,
    output logic                       overflow
);

    localparam int PW  = CHANNELS * DW;
    localparam int XW  = idx_w(WIDTH);
    localparam int YW  = idx_w(HEIGHT);
    localparam int DFW = DW + DIFF_EXTRA;
    localparam logic [XW-1:0]    X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [DFW-1:0]   TOL_V   = DFW'(TOL);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_e       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [XW-1:0]    first_x_q, first_x_d;
    logic [YW-1:0]    first_y_q, first_y_d;
    logic             err_seen_q, err_seen_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             in_run;
    logic             dut_wr, ref_wr;
    logic             dut_full, dut_empty, ref_full, ref_empty;
    logic             pop;
    logic             mismatch;
    logic [PW-1:0]    dut_head, ref_head;
    logic [DFW-1:0]   ch_a, ch_b, ch_diff;

    // Start in the same cycle as data wins: the FIFOs are flushed and writes dropped.
    assign in_run = (state_q == ST_RUN);
    assign dut_wr = in_run && !start && dut_valid;
    assign ref_wr = in_run && !start && ref_valid;
    assign pop    = in_run && !start && !dut_empty && !ref_empty;

    stream_fifo #(.DW_TOTAL(PW), .DEPTH(FIFO_DEPTH)) u_dut_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .flush   (start),
        .wr_en   (dut_wr),
        .wr_data (dut_data),
        .rd_en   (pop),
        .rd_data (dut_head),
        .full    (dut_full),
        .empty   (dut_empty)
    );

    stream_fifo #(.DW_TOTAL(PW), .DEPTH(FIFO_DEPTH)) u_ref_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .flush   (start),
        .wr_en   (ref_wr),
        .wr_data (ref_data),
        .rd_en   (pop),
        .rd_data (ref_head),
        .full    (ref_full),
        .empty   (ref_empty)
    );

    always_comb begin
        mismatch = 1'b0;
        ch_a     = '0;
        ch_b     = '0;
        ch_diff  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_a    = {1'b0, dut_head[chan_lsb(c, DW) +: DW]};
            ch_b    = {1'b0, ref_head[chan_lsb(c, DW) +: DW]};
            ch_diff = (ch_a >= ch_b) ? (ch_a - ch_b) : (ch_b - ch_a);
            if (ch_diff > TOL_V) mismatch = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        err_cnt_d  = err_cnt_q;
        first_x_d  = first_x_q;
        first_y_d  = first_y_q;
        err_seen_d = err_seen_q;
        overflow_d = overflow_q;
        if (start) begin
            state_d    = ST_RUN;
            x_d        = '0;
            y_d        = '0;
            err_cnt_d  = '0;
            first_x_d  = '0;
            first_y_d  = '0;
            err_seen_d = 1'b0;
            overflow_d = 1'b0;
        end else if (in_run) begin
            if (!pop && ((dut_valid && dut_full) || (ref_valid && ref_full))) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (!err_seen_q) begin
                        err_seen_d = 1'b1;
                        first_x_d  = x_q;
                        first_y_d  = y_q;
                    end
                end
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_cnt_d == '0) && !overflow_d;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            err_cnt_q  <= '0;
            first_x_q  <= '0;
            first_y_q  <= '0;
            err_seen_q <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_cnt_q  <= err_cnt_d;
            first_x_q  <= first_x_d;
            first_y_q  <= first_y_d;
            err_seen_q <= err_seen_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_cnt_q;
    assign first_err_x = first_x_q;
    assign first_err_y = first_y_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_img_stream_checker.sv
// Bench for img_stream_checker: frame table, hand-written corner sequences and
// randomized frames against a queue-based reference model.
module tb_img_stream_checker;

    localparam int W = 4, H = 2, CH = 3, DW = 8, FD = 4, NPIX = W * H;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic        dut_valid = 1'b0, ref_valid = 1'b0;
    logic [23:0] dut_data = '0, ref_data = '0;

    logic        busy0, done0, pass0, ovf0, busy1, done1, pass1, ovf1;
    logic [15:0] err0, err1;
    logic [1:0]  fx0, fx1;
    logic [0:0]  fy0, fy1;

    int n_vec = 0;
    int n_err = 0;

    img_stream_checker #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .DW(DW),
                         .FIFO_DEPTH(FD), .TOL(0), .ERR_W(16)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start),
        .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_x(fx0), .first_err_y(fy0), .overflow(ovf0)
    );

    img_stream_checker #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .DW(DW),
                         .FIFO_DEPTH(FD), .TOL(1), .ERR_W(16)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start),
        .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_data(ref_data),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_x(fx1), .first_err_y(fy1), .overflow(ovf1)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int i);
        logic [7:0] r, g, b;
        r = 8'(i * 7 + 3);
        g = 8'(i + 8'h40);
        b = 8'(i * 3 + 11);
        return {b, g, r};
    endfunction

    task automatic do_start();
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(done0 && done1) && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", {31'd0, done0 && done1}, 1);
    endtask

    // Drive n pixels on the DUT side; ref copy lags by delay cycles. One channel
    // of pixel bad_idx may be overridden differently on each side.
    task automatic drive_pixels(input int n, input int delay, input int bad_idx,
                                input int bad_ch, input logic [7:0] dv, input logic [7:0] rv);
        logic [23:0] dp, rp;
        for (int c = 0; c < n + delay; c++) begin
            dp = pix(c);
            rp = pix(c - delay);
            if (c == bad_idx) dp[bad_ch*8 +: 8] = dv;
            if (c - delay == bad_idx) rp[bad_ch*8 +: 8] = rv;
            dut_valid = (c < n);
            ref_valid = (c >= delay) && (c - delay < n);
            dut_data  = dp;
            ref_data  = rp;
            tick();
        end
        dut_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit          m_run;
    logic [23:0] mdq[$];
    logic [23:0] mrq[$];
    int          m_cmp;
    int          m_err[2];
    int          m_first[2];
    bit          m_ovf;

    function automatic bit mism(input logic [23:0] a, input logic [23:0] b, input int tol);
        int da, db, d;
        for (int c = 0; c < CH; c++) begin
            da = int'(a[c*8 +: 8]);
            db = int'(b[c*8 +: 8]);
            d  = (da > db) ? da - db : db - da;
            if (d > tol) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_start();
        m_run = 1'b1;
        mdq.delete();
        mrq.delete();
        m_cmp = 0;
        m_ovf = 1'b0;
        for (int t = 0; t < 2; t++) begin
            m_err[t]   = 0;
            m_first[t] = 0;
        end
    endtask

    task automatic m_step(input bit dv, input logic [23:0] dd, input bit rv, input logic [23:0] rd);
        logic [23:0] a, b;
        bit popped;
        if (!m_run) return;
        popped = (mdq.size() > 0) && (mrq.size() > 0);
        if (popped) begin
            a = mdq.pop_front();
            b = mrq.pop_front();
            for (int t = 0; t < 2; t++) begin
                if (mism(a, b, t)) begin
                    if (m_err[t] == 0) m_first[t] = m_cmp;
                    m_err[t]++;
                end
            end
            m_cmp++;
            if (m_cmp == NPIX) m_run = 1'b0;
        end
        if (dv) begin
            if (mdq.size() < FD) mdq.push_back(dd);
            else m_ovf = 1'b1;
        end
        if (rv) begin
            if (mrq.size() < FD) mrq.push_back(rd);
            else m_ovf = 1'b1;
        end
    endtask

    typedef struct {
        int         delay;
        int         bad_idx;
        int         bad_ch;
        logic [7:0] dv;
        logic [7:0] rv;
        int         exp_err0;
        int         exp_fx;
        int         exp_fy;
        int         exp_err1;
        bit         exp_pass0;
        bit         exp_pass1;
    } vec_t;

    vec_t        vecs[5];
    logic [23:0] g[256];

    initial begin
        int pd, pr, dk, rk, cyc, ch;
        bit dv, rv;
        logic [23:0] tmp;

        // reset state
        #2;
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_done", {31'd0, done0}, 0);
        chk("rst_pass", {31'd0, pass0}, 0);
        chk("rst_err", {16'd0, err0}, 0);
        chk("rst_ovf", {31'd0, ovf0}, 0);
        tick();
        HRESET = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy0}, 0);

        //              delay bad ch  dv     rv     e0 fx fy e1 p0 p1
        vecs[0] = '{0,  -1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1};
        vecs[1] = '{3,  -1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1};
        vecs[2] = '{0,   5, 1, 8'h41, 8'h40, 1, 1, 1, 0, 0, 1};
        vecs[3] = '{0,   2, 0, 8'h00, 8'hFF, 1, 2, 0, 1, 0, 0};
        vecs[4] = '{2,   7, 2, 8'hFF, 8'h00, 1, 3, 1, 1, 0, 0};

        for (int i = 0; i < 5; i++) begin
            do_start();
            chk($sformatf("row%0d_busy", i), {31'd0, busy0}, 1);
            drive_pixels(NPIX, vecs[i].delay, vecs[i].bad_idx, vecs[i].bad_ch, vecs[i].dv, vecs[i].rv);
            wait_done(20);
            chk($sformatf("row%0d_busy_done", i), {31'd0, busy0}, 0);
            chk($sformatf("row%0d_err0", i), {16'd0, err0}, vecs[i].exp_err0);
            chk($sformatf("row%0d_fx0", i), {30'd0, fx0}, vecs[i].exp_fx);
            chk($sformatf("row%0d_fy0", i), {31'd0, fy0}, vecs[i].exp_fy);
            chk($sformatf("row%0d_ovf0", i), {31'd0, ovf0}, 0);
            chk($sformatf("row%0d_pass0", i), {31'd0, pass0}, {31'd0, vecs[i].exp_pass0});
            chk($sformatf("row%0d_err1", i), {16'd0, err1}, vecs[i].exp_err1);
            chk($sformatf("row%0d_pass1", i), {31'd0, pass1}, {31'd0, vecs[i].exp_pass1});
        end

        // compare latency: written on one edge, result visible after the next
        do_start();
        dut_valid = 1'b1; dut_data = 24'h000001;
        ref_valid = 1'b1; ref_data = 24'h000000;
        tick();
        dut_valid = 1'b0; ref_valid = 1'b0;
        chk("lat_before", {16'd0, err0}, 0);
        tick();
        chk("lat_after", {16'd0, err0}, 1);
        drive_pixels(NPIX - 1, 0, -1, 0, 8'h00, 8'h00);
        wait_done(20);
        chk("lat_pass", {31'd0, pass0}, 0);
        chk("lat_err", {16'd0, err0}, 1);

        // overflow: DUT stream into a full FIFO while ref is idle
        do_start();
        for (int c = 0; c < 6; c++) begin
            dut_valid = 1'b1; dut_data = 24'h123456;
            tick();
            chk($sformatf("ovf_c%0d", c), {31'd0, ovf0}, (c >= 4) ? 1 : 0);
        end
        for (int c = 0; c < 12; c++) begin
            dut_valid = 1'b1; dut_data = 24'h123456;
            ref_valid = 1'b1; ref_data = 24'h123456;
            tick();
        end
        dut_valid = 1'b0; ref_valid = 1'b0;
        wait_done(20);
        chk("ovf_sticky", {31'd0, ovf0}, 1);
        chk("ovf_err", {16'd0, err0}, 0);
        chk("ovf_pass", {31'd0, pass0}, 0);
        do_start();
        chk("ovf_cleared", {31'd0, ovf0}, 0);

        // reset mid-frame
        drive_pixels(3, 0, 0, 0, 8'hAA, 8'h55);
        tick();
        chk("pre_rst_err", {16'd0, err0}, 1);
        HRESET = 1'b1;
        #2;
        chk("midrst_busy", {31'd0, busy0}, 0);
        chk("midrst_done", {31'd0, done0}, 0);
        chk("midrst_err", {16'd0, err0}, 0);
        chk("midrst_pass", {31'd0, pass0}, 0);
        tick();
        HRESET = 1'b0;
        tick();
        do_start();
        drive_pixels(NPIX, 0, -1, 0, 8'h00, 8'h00);
        wait_done(20);
        chk("postrst_pass", {31'd0, pass0}, 1);
        chk("postrst_err", {16'd0, err0}, 0);

        // start while running clears counters and first-error latch
        do_start();
        drive_pixels(5, 0, 2, 0, 8'h10, 8'h20);
        tick();
        chk("mid_err", {16'd0, err0}, 1);
        chk("mid_fx", {30'd0, fx0}, 2);
        do_start();
        chk("restart_err", {16'd0, err0}, 0);
        chk("restart_fx", {30'd0, fx0}, 0);
        chk("restart_busy", {31'd0, busy0}, 1);
        drive_pixels(NPIX, 1, -1, 0, 8'h00, 8'h00);
        wait_done(20);
        chk("restart_pass", {31'd0, pass0}, 1);

        // randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 2))
                0: pd = 40;
                1: pd = 75;
                default: pd = 100;
            endcase
            pr = 30 + $urandom_range(0, 70);
            for (int k = 0; k < 256; k++) g[k] = 24'($urandom);
            m_start();
            do_start();
            dk = 0; rk = 0; cyc = 0;
            while (m_run && cyc < 300) begin
                dv = ($urandom_range(0, 99) < pd);
                rv = ($urandom_range(0, 99) < pr);
                tmp = g[dk % 256];
                if ($urandom_range(0, 5) == 0) begin
                    ch = $urandom_range(0, 2);
                    if ($urandom_range(0, 2) == 0) tmp[ch*8 +: 8] = ~tmp[ch*8 +: 8];
                    else tmp[ch*8 +: 8] = tmp[ch*8 +: 8] + 8'($urandom_range(1, 2));
                end
                dut_valid = dv; dut_data = tmp;
                ref_valid = rv; ref_data = g[rk % 256];
                if (dv) dk++;
                if (rv) rk++;
                m_step(dv, dut_data, rv, ref_data);
                tick();
                cyc++;
            end
            dut_valid = 1'b0; ref_valid = 1'b0;
            chk($sformatf("rnd%0d_model_done", f), {31'd0, m_run}, 0);
            chk($sformatf("rnd%0d_done", f), {30'd0, done1, done0}, 3);
            chk($sformatf("rnd%0d_err0", f), {16'd0, err0}, m_err[0]);
            chk($sformatf("rnd%0d_err1", f), {16'd0, err1}, m_err[1]);
            chk($sformatf("rnd%0d_fx0", f), {30'd0, fx0}, (m_err[0] > 0) ? m_first[0] % W : 0);
            chk($sformatf("rnd%0d_fy0", f), {31'd0, fy0}, (m_err[0] > 0) ? m_first[0] / W : 0);
            chk($sformatf("rnd%0d_fx1", f), {30'd0, fx1}, (m_err[1] > 0) ? m_first[1] % W : 0);
            chk($sformatf("rnd%0d_ovf", f), {30'd0, ovf1, ovf0}, m_ovf ? 3 : 0);
            chk($sformatf("rnd%0d_pass0", f), {31'd0, pass0}, (m_err[0] == 0 && !m_ovf) ? 1 : 0);
            chk($sformatf("rnd%0d_pass1", f), {31'd0, pass1}, (m_err[1] == 0 && !m_ovf) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
